usb_tx_data_buffer: RTL and testbench
=====================================

// Module: usb_tx_data_buffer
// PURPOSE
//   Byte FIFO directly upstream of usb_tx. The endpoint/AHB side pushes payload bytes.
//   usb_tx pops one byte per get_tx_packet pulse.
//   Supplies tx_packet_data (show-ahead head byte) and tx_packet_data_size (occupancy).
//   Flags overflow/underflow and supports a synchronous flush between packets.
// PARAMETERS
//   DEPTH   64  number of byte entries; must be a power of two
//   ADDR_W  6   log2(DEPTH); pointer width
//   DATA_W  8   entry width in bits
// PORTS
//   clk                  in   1         system clock; all logic on rising edge
//   rst                  in   1         synchronous, active-high reset
//   clear                in   1         synchronous flush: empties FIFO, clears flags
//   store_tx_data        in   1         push strobe, one byte per cycle high
//   tx_data_in           in   DATA_W    byte to push, sampled when store_tx_data=1
//   get_tx_packet        in   1         pop strobe from usb_tx, one byte per cycle high
//   tx_packet_data       out  DATA_W    head byte, valid whenever tx_packet_data_size>0
//   tx_packet_data_size  out  ADDR_W+1  occupancy, 0..DEPTH
//   buffer_full          out  1         tx_packet_data_size==DEPTH
//   buffer_empty         out  1         tx_packet_data_size==0
//   overflow             out  1         sticky; push rejected
//   underflow            out  1         sticky; pop while empty
// BEHAVIOUR
//   Reset (rst=1 at clk edge): rd_ptr=wr_ptr=0, count=0, overflow=underflow=0.
//     Outputs after reset: tx_packet_data=0, size=0, empty=1, full=0.
//     Memory contents are not reset.
//   Priority each cycle: rst > clear > push/pop.
//     clear has the same effect as rst on pointers, count and flags.
//     A push or pop in the same cycle as clear is discarded.
//   Storage: DEPTH x DATA_W register array. Pointers are ADDR_W bits and wrap naturally
//     from DEPTH-1 to 0.
//   Push accepted iff store_tx_data & (count<DEPTH | pop_accepted).
//     Accepted push writes mem[wr_ptr] and increments wr_ptr.
//   Pop accepted iff get_tx_packet & count>0. Accepted pop increments rd_ptr.
//   count: +1 on push only; -1 on pop only; unchanged on both or neither.
//   Full with push+pop in the same cycle: both accepted, count stays DEPTH, no overflow.
//   Empty with push+pop in the same cycle:
//     pop rejected, underflow=1, push accepted, count becomes 1.
//   Rejected push sets overflow. Rejected pop sets underflow.
//     Both flags hold until rst or clear.
//   tx_packet_data is combinational from mem[rd_ptr] when count>0, otherwise 0.
//     Zero latency from the head: the byte shown is the byte popped.
//     After a pop, the next byte appears in the following cycle.
//   Write-to-read latency: a byte pushed at edge N is visible on tx_packet_data
//     after edge N, if the FIFO was empty.
//   size, full and empty are taken straight from the count register; no extra pipeline stage.
//   Reset or clear mid-packet immediately empties the FIFO.
//     usb_tx then reads size=0; this FIFO does not handle packet abort.
// TESTING
//   1 Reset: assert rst 2 cycles -> size=0, empty=1, data=0x00, overflow=underflow=0.
//   2 Ordering: push 0xA5, 0x3C, 0x00, 0xFF -> size=4, data=0xA5.
//     Then 4 pops give 0xA5, 0x3C, 0x00, 0xFF, then empty=1.
//   3 Full/overflow: push 64 bytes -> full=1, size=64.
//     Push 65th (0x77) -> overflow=1, size=64, 0x77 never popped.
//   4 Simultaneous: push 0x11 and pop at size=64 -> size=64, no overflow.
//     Push+pop at size=0 -> underflow=1, size=1, data=0x11.
//   5 Wrap: 3 rounds of push 40 / pop 40, values i^0x5A -> every pop matches, size=0 at end.
//   6 Clear: 10 bytes loaded, overflow set; clear with push+pop in the same cycle
//     -> size=0, flags=0, next push 0x42 shows data=0x42.

Source files
------------

// File: rtl/usb_tx_data_buffer_if.sv
// ---------------------------------------------------------------------------
// usb_tx_data_buffer_if
//   Bundles the push/pop handshake and status signals of the USB transmit
//   byte FIFO so the endpoint side, usb_tx and the FIFO share one connection.
//
//   Signals
//     clear                flush request from the packet sequencer
//     store_tx_data        push strobe, one byte per cycle high
//     tx_data_in           byte to push
//     get_tx_packet        pop strobe from usb_tx
//     tx_packet_data       head byte (show-ahead)
//     tx_packet_data_size  occupancy, 0..DEPTH
//     buffer_full          occupancy equals DEPTH
//     buffer_empty         occupancy equals zero
//     overflow             sticky, a push was rejected
//     underflow            sticky, a pop was rejected
//
//   Modports
//     master  the side that drives push/pop/clear and watches status
//     slave   the FIFO itself
// ---------------------------------------------------------------------------
interface usb_tx_data_buffer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              clear;
    logic              store_tx_data;
    logic [DATA_W-1:0] tx_data_in;
    logic              get_tx_packet;
    logic [DATA_W-1:0] tx_packet_data;
    logic [ADDR_W:0]   tx_packet_data_size;
    logic              buffer_full;
    logic              buffer_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear,
        output store_tx_data,
        output tx_data_in,
        output get_tx_packet,
        input  tx_packet_data,
        input  tx_packet_data_size,
        input  buffer_full,
        input  buffer_empty,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  clear,
        input  store_tx_data,
        input  tx_data_in,
        input  get_tx_packet,
        output tx_packet_data,
        output tx_packet_data_size,
        output buffer_full,
        output buffer_empty,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/usb_tx_data_buffer.sv
// ---------------------------------------------------------------------------
// usb_tx_data_buffer
//   Byte FIFO sitting directly upstream of usb_tx. The endpoint side pushes
//   payload bytes; usb_tx pops one byte per get_tx_packet pulse and always
//   sees the head byte combinationally (show-ahead), plus the current
//   occupancy. Rejected pushes and pops raise sticky flags that stay set
//   until reset or a flush between packets.
//
//   Ports
//     clk   system clock, all state on the rising edge
//     rst   synchronous active-high reset
//     bus   usb_tx_data_buffer_if.slave, push/pop/clear and status
// ---------------------------------------------------------------------------
module usb_tx_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    usb_tx_data_buffer_if.slave bus
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              pop_ok;
    logic              push_ok;
    logic              flush;

    // Acceptance decisions. A pop needs something to read. A push needs
    // room, except that a pop in the same cycle frees the slot being
    // written, so a full FIFO can still stream one-in/one-out. On an empty
    // FIFO the pop is refused even if a push arrives together with it,
    // because the pushed byte is not readable until the next cycle.
    always_comb begin
        flush   = rst | bus.clear;
        pop_ok  = bus.get_tx_packet & (count != '0);
        push_ok = bus.store_tx_data & ((count != FULL_COUNT) | pop_ok);
    end

    // Storage array is deliberately left out of reset; only the pointers
    // decide what is valid. Writes are suppressed during reset/flush so a
    // push coinciding with a flush is truly discarded.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            mem[wr_ptr] <= bus.tx_data_in;
        end
    end

    // Pointers and occupancy. Reset and clear behave identically and take
    // precedence over any push/pop in the same cycle. Pointers are exactly
    // ADDR_W bits wide so they wrap from DEPTH-1 to 0 on their own.
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. Each one latches the first refused request and
    // only a reset or flush drops it again.
    always_ff @(posedge clk) begin
        if (flush) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.store_tx_data && !push_ok) begin
                bus.overflow <= 1'b1;
            end
            if (bus.get_tx_packet && !pop_ok) begin
                bus.underflow <= 1'b1;
            end
        end
    end

    // Status straight from the count register with no extra stage. The head
    // byte is forced to zero when empty so usb_tx never sees stale memory.
    always_comb begin
        bus.tx_packet_data_size = count;
        bus.buffer_full         = (count == FULL_COUNT);
        bus.buffer_empty        = (count == '0);
        bus.tx_packet_data      = (count != '0) ? mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_data_buffer
//   Directed bench for usb_tx_data_buffer: reset, ordering, full/overflow,
//   simultaneous push/pop at both boundaries, pointer wrap and flush.
// ---------------------------------------------------------------------------
module tb_usb_tx_data_buffer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    usb_tx_data_buffer_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    usb_tx_data_buffer #(.DEPTH(64), .ADDR_W(6), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then return to idle with
    // outputs settled one time unit after the edge
    task automatic applyStimulus(input logic st, input logic [7:0] d,
                                 input logic gp, input logic clr);
        bus.store_tx_data = st;
        bus.tx_data_in    = d;
        bus.get_tx_packet = gp;
        bus.clear         = clr;
        @(posedge clk);
        #1;
        bus.store_tx_data = 1'b0;
        bus.tx_data_in    = 8'h00;
        bus.get_tx_packet = 1'b0;
        bus.clear         = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
    endtask

    // Head byte must equal the expected value before it is popped
    task automatic popCheck(input string tag, input logic [7:0] expected);
        checkOutput(tag, 32'(bus.tx_packet_data), 32'(expected));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] order [4];
        vectors     = 0;
        miscompares = 0;
        order[0] = 8'hA5;
        order[1] = 8'h3C;
        order[2] = 8'h00;
        order[3] = 8'hFF;

        bus.store_tx_data = 1'b0;
        bus.tx_data_in    = 8'h00;
        bus.get_tx_packet = 1'b0;
        bus.clear         = 1'b0;

        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_size",  32'(bus.tx_packet_data_size), 32'd0);
        checkOutput("reset_empty", 32'(bus.buffer_empty), 32'd1);
        checkOutput("reset_full",  32'(bus.buffer_full), 32'd0);
        checkOutput("reset_data",  32'(bus.tx_packet_data), 32'h00);
        checkOutput("reset_ovf",   32'(bus.overflow), 32'd0);
        checkOutput("reset_unf",   32'(bus.underflow), 32'd0);

        // Ordering through the show-ahead head
        pushByte(order[0]);
        checkOutput("first_push_data", 32'(bus.tx_packet_data), 32'hA5);
        for (int i = 1; i < 4; i++) pushByte(order[i]);
        checkOutput("order_size", 32'(bus.tx_packet_data_size), 32'd4);
        checkOutput("order_head", 32'(bus.tx_packet_data), 32'hA5);
        for (int i = 0; i < 4; i++) popCheck("order_pop", order[i]);
        checkOutput("order_empty", 32'(bus.buffer_empty), 32'd1);
        checkOutput("order_empty_data", 32'(bus.tx_packet_data), 32'h00);
        checkOutput("order_no_unf", 32'(bus.underflow), 32'd0);

        // Fill to capacity, then one more push is refused
        for (int i = 0; i < 64; i++) pushByte(8'(i));
        checkOutput("fill_full", 32'(bus.buffer_full), 32'd1);
        checkOutput("fill_size", 32'(bus.tx_packet_data_size), 32'd64);
        checkOutput("fill_no_ovf", 32'(bus.overflow), 32'd0);
        pushByte(8'h77);
        checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_size", 32'(bus.tx_packet_data_size), 32'd64);
        for (int i = 0; i < 64; i++) popCheck("ovf_drain", 8'(i));
        checkOutput("ovf_drain_empty", 32'(bus.buffer_empty), 32'd1);
        checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clear_ovf", 32'(bus.overflow), 32'd0);

        // Push+pop while full: both accepted, no overflow
        for (int i = 0; i < 64; i++) pushByte(8'(i + 8'h80));
        checkOutput("full2_size", 32'(bus.tx_packet_data_size), 32'd64);
        checkOutput("full2_head", 32'(bus.tx_packet_data), 32'h80);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        checkOutput("simul_full_size", 32'(bus.tx_packet_data_size), 32'd64);
        checkOutput("simul_full_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("simul_full_head", 32'(bus.tx_packet_data), 32'h81);
        for (int i = 1; i < 64; i++) popCheck("simul_drain", 8'(i + 8'h80));
        checkOutput("simul_tail_size", 32'(bus.tx_packet_data_size), 32'd1);
        popCheck("simul_tail", 8'h11);
        checkOutput("simul_tail_unf", 32'(bus.underflow), 32'd0);

        // Push+pop while empty: pop refused, push lands
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        checkOutput("simul_empty_unf", 32'(bus.underflow), 32'd1);
        checkOutput("simul_empty_size", 32'(bus.tx_packet_data_size), 32'd1);
        checkOutput("simul_empty_data", 32'(bus.tx_packet_data), 32'h11);
        popCheck("simul_empty_pop", 8'h11);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clear_unf", 32'(bus.underflow), 32'd0);

        // Three rounds of 40 in / 40 out walk the pointers past the wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) pushByte(8'(i) ^ 8'h5A);
            checkOutput("wrap_size", 32'(bus.tx_packet_data_size), 32'd40);
            for (int i = 0; i < 40; i++) popCheck("wrap_pop", 8'(i) ^ 8'h5A);
        end
        checkOutput("wrap_end_size", 32'(bus.tx_packet_data_size), 32'd0);
        checkOutput("wrap_end_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

        // Overflow raised, then 10 bytes left before the flush
        for (int i = 0; i < 64; i++) pushByte(8'(i + 8'h20));
        pushByte(8'hEE);
        for (int i = 0; i < 54; i++) popCheck("pre_clear_pop", 8'(i + 8'h20));
        checkOutput("pre_clear_size", 32'(bus.tx_packet_data_size), 32'd10);
        checkOutput("pre_clear_ovf", 32'(bus.overflow), 32'd1);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        checkOutput("clear_size", 32'(bus.tx_packet_data_size), 32'd0);
        checkOutput("clear_empty", 32'(bus.buffer_empty), 32'd1);
        checkOutput("clear_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
        checkOutput("clear_data", 32'(bus.tx_packet_data), 32'h00);
        pushByte(8'h42);
        checkOutput("post_clear_data", 32'(bus.tx_packet_data), 32'h42);
        checkOutput("post_clear_size", 32'(bus.tx_packet_data_size), 32'd1);

        // Reset mid-packet empties immediately
        pushByte(8'h55);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_size", 32'(bus.tx_packet_data_size), 32'd0);
        checkOutput("midrst_data", 32'(bus.tx_packet_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
